reg_mst_arbiter: RTL

//  Shares one register-slave FSM port among N_MST register masters (e.g. APB bridge, debug port, DMA cfg).

---
 rtl/reg_mst_arbiter_pkg.sv | 10 +
 rtl/reg_mst_arbiter_if.sv | 44 ++++
 rtl/reg_mst_arbiter_rr_pick.sv | 35 +++
 rtl/reg_mst_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/reg_mst_arbiter_pkg.sv
// Shared types and sizing for the register-master arbiter.
package reg_arb_pkg;

   // The grant index is sized for the largest supported master count (8).
   localparam int unsigned MAX_MST = 8;
   localparam int unsigned GRANT_W = $clog2(MAX_MST);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT, ERR} arb_state_e;

endpackage

// File: rtl/reg_mst_arbiter_if.sv
// Master-side request/response bundle plus the slave-FSM-side port of the arbiter.
interface reg_mst_arbiter_if #(
   parameter int unsigned N_MST      = 4,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [N_MST-1:0]            mst__arb__req_vld;
   logic [N_MST-1:0]            mst__arb__rd_en;
   logic [N_MST-1:0]            mst__arb__wr_en;
   logic [N_MST*ADDR_WIDTH-1:0] mst__arb__addr;
   logic [N_MST*DATA_WIDTH-1:0] mst__arb__wr_data;
   logic                        mst__arb__sync_reset;
   logic [N_MST-1:0]            arb__mst__ack_vld;
   logic                        arb__mst__err;
   logic [DATA_WIDTH-1:0]       arb__mst__rd_data;
   logic                        arb__fsm__req_vld;
   logic                        arb__fsm__rd_en;
   logic                        arb__fsm__wr_en;
   logic [ADDR_WIDTH-1:0]       arb__fsm__addr;
   logic [DATA_WIDTH-1:0]       arb__fsm__wr_data;
   logic                        arb__fsm__sync_reset;
   logic                        fsm__arb__ack_vld;
   logic [DATA_WIDTH-1:0]       fsm__arb__rd_data;
   logic                        arb__idle;

   // Arbiter view.
   modport slave (
      input  mst__arb__req_vld, mst__arb__rd_en, mst__arb__wr_en, mst__arb__addr,
             mst__arb__wr_data, mst__arb__sync_reset, fsm__arb__ack_vld, fsm__arb__rd_data,
      output arb__mst__ack_vld, arb__mst__err, arb__mst__rd_data, arb__fsm__req_vld,
             arb__fsm__rd_en, arb__fsm__wr_en, arb__fsm__addr, arb__fsm__wr_data,
             arb__fsm__sync_reset, arb__idle
   );

   // Requesting masters and downstream slave FSM view.
   modport master (
      output mst__arb__req_vld, mst__arb__rd_en, mst__arb__wr_en, mst__arb__addr,
             mst__arb__wr_data, mst__arb__sync_reset, fsm__arb__ack_vld, fsm__arb__rd_data,
      input  arb__mst__ack_vld, arb__mst__err, arb__mst__rd_data, arb__fsm__req_vld,
             arb__fsm__rd_en, arb__fsm__wr_en, arb__fsm__addr, arb__fsm__wr_data,
             arb__fsm__sync_reset, arb__idle
   );

endinterface

// File: rtl/reg_mst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module reg_rr_pick
   import reg_arb_pkg::*;
#(
   parameter int unsigned N_MST = 4
) (
   input  logic [N_MST-1:0]   req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [N_MST-1:0]   grant,
   output logic [GRANT_W-1:0] idx,
   output logic               any
);
   logic [N_MST-1:0] rot;
   int               off;
   int               sum;

   // Rotate so that bit 0 is the master at ptr.
   assign rot = N_MST'({req, req} >> ptr);

   always_comb begin
      any = 1'b0;
      off = 0;
      for (int i = 0; i < int'(N_MST); i++) begin
         if (!any && rot[i]) begin
            any = 1'b1;
            off = i;
         end
      end
      sum = int'(ptr) + off;
      if (sum >= int'(N_MST)) sum = sum - int'(N_MST);
      idx   = GRANT_W'(sum);
      grant = any ? (N_MST'(1) << idx) : '0;
   end

endmodule

// File: rtl/reg_mst_arbiter.sv
// Round-robin arbiter sharing one register-slave FSM port among N_MST masters,
// one transaction at a time, with a watchdog that aborts hung accesses.
module reg_mst_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned N_MST      = 4,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic              clk,
   input logic              rst,
   reg_mst_arbiter_if.slave bus
);
   localparam int unsigned   TW         = $clog2(TIMEOUT + 2);
   localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_e            state_q, state_d;
   logic [GRANT_W-1:0]    ptr_q, ptr_d, gidx_q, ptr_adv;
   logic [N_MST-1:0]      goh_q;
   logic                  rd_q, wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [TW-1:0]         timer_q, timer_d;

   logic [N_MST-1:0]      pick_oh;
   logic [GRANT_W-1:0]    pick_idx;
   logic                  pick_any;
   logic                  sel_rd, sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  grant_load, ack_fire, err_fire, pass_data;

   reg_rr_pick #(.N_MST(N_MST)) u_pick (
      .req   (bus.mst__arb__req_vld),
      .ptr   (ptr_q),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < int'(N_MST); i++) begin
         if (pick_oh[i]) begin
            sel_rd    = bus.mst__arb__rd_en[i];
            sel_wr    = bus.mst__arb__wr_en[i];
            sel_addr  = bus.mst__arb__addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.mst__arb__wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ptr_adv = (gidx_q == GRANT_W'(N_MST - 1)) ? '0 : gidx_q + GRANT_W'(1);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      timer_d    = timer_q;
      grant_load = 1'b0;
      ack_fire   = 1'b0;
      err_fire   = 1'b0;
      pass_data  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_load = 1'b1;
               timer_d    = '0;
               state_d    = (sel_rd == sel_wr) ? ERR : BUSY;
            end
         end
         BUSY: begin
            if (timer_q != '1) timer_d = timer_q + TW'(1);
            if (bus.fsm__arb__ack_vld) begin
               ack_fire  = 1'b1;
               pass_data = 1'b1;
               ptr_d     = ptr_adv;
               state_d   = IDLE;
            end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
               state_d = ABORT;
            end
         end
         ABORT, ERR: begin
            ack_fire = 1'b1;
            err_fire = 1'b1;
            ptr_d    = ptr_adv;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Soft reset drops the transaction silently and keeps the rotation where it was.
      if (bus.mst__arb__sync_reset) begin
         state_d    = IDLE;
         ptr_d      = ptr_q;
         grant_load = 1'b0;
         ack_fire   = 1'b0;
         err_fire   = 1'b0;
         pass_data  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         timer_q <= '0;
         gidx_q  <= '0;
         goh_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         if (grant_load) begin
            gidx_q  <= pick_idx;
            goh_q   <= pick_oh;
            rd_q    <= sel_rd;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
      end
   end

   assign bus.arb__mst__ack_vld    = ack_fire ? goh_q : '0;
   assign bus.arb__mst__err        = err_fire;
   assign bus.arb__mst__rd_data    = pass_data ? bus.fsm__arb__rd_data : '0;
   assign bus.arb__fsm__req_vld    = (state_q == BUSY);
   assign bus.arb__fsm__rd_en      = rd_q;
   assign bus.arb__fsm__wr_en      = wr_q;
   assign bus.arb__fsm__addr       = addr_q;
   assign bus.arb__fsm__wr_data    = wdata_q;
   assign bus.arb__fsm__sync_reset = bus.mst__arb__sync_reset | (state_q == ABORT);
   assign bus.arb__idle            = (state_q == IDLE);

endmodule
